// File: rtl/forward_registered_pipe_if.sv
// Valid/ready bundle around forward_registered_pipe: upstream (m_*) and downstream (s_*) links.
// The slave modport is the pipe's view; the master modport is the surrounding logic's view.
interface forward_registered_pipe_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  modport slave (
    input  m_valid, m_data, s_ready,
    output m_ready, s_valid, s_data
  );

  modport master (
    output m_valid, m_data, s_ready,
    input  m_ready, s_valid, s_data
  );
endinterface

// File: rtl/forward_registered_pipe.sv
// DEPTH-stage valid/ready pipeline with every stage registering valid and data.
// Empty stages are always ready, so bubbles collapse under downstream stall.
module forward_registered_pipe #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  forward_registered_pipe_if.slave bus,
  output logic [CNT_W-1:0]        occupancy
);

  logic             r_vld [DEPTH];
  logic [WIDTH-1:0] r_dat [DEPTH];

  logic [DEPTH-1:0] w_rdy;
  logic             w_in_vld [DEPTH];
  logic [WIDTH-1:0] w_in_dat [DEPTH];

  // Ready ripples from the output stage back towards the master.
  always_comb begin
    w_rdy            = '0;
    w_rdy[DEPTH-1]   = bus.s_ready | ~r_vld[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_rdy[i] = w_rdy[i+1] | ~r_vld[i];
    end
  end

  assign bus.m_ready = w_rdy[0] & ~flush;
  assign bus.s_valid = r_vld[DEPTH-1];
  assign bus.s_data  = r_dat[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_in_vld[gi] = bus.m_valid;
        assign w_in_dat[gi] = bus.m_data;
      end else begin : g_body
        assign w_in_vld[gi] = r_vld[gi-1];
        assign w_in_dat[gi] = r_dat[gi-1];
      end

      // Data only moves with a valid beat, so idle cycles never disturb held payloads.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld[gi] <= 1'b0;
          r_dat[gi] <= '0;
        end else if (flush) begin
          r_vld[gi] <= 1'b0;
        end else if (w_rdy[gi]) begin
          r_vld[gi] <= w_in_vld[gi];
          if (w_in_vld[gi]) begin
            r_dat[gi] <= w_in_dat[gi];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(r_vld[i]);
    end
  end

endmodule

// File: tb/tb_forward_registered_pipe.sv
// Directed bench for forward_registered_pipe (WIDTH=8, DEPTH=3): streaming, backpressure,
// bubble collapse, flush and mid-stream reset, with hand-computed expectations.
module tb_forward_registered_pipe;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  forward_registered_pipe_if #(.WIDTH(8)) bus ();

  forward_registered_pipe #(
    .WIDTH(8),
    .DEPTH(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && bus.m_valid && bus.m_ready) $display("in  data=%02h", bus.m_data);
    if (rst_n && bus.s_valid && bus.s_ready) $display("out data=%02h", bus.s_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] d);
    bus.m_valid = v;
    bus.m_data  = d;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_data  = 8'h00;
    bus.s_ready = 1'b0;

    // Reset then idle
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check("rst_s_valid", 32'(bus.s_valid), 0);
    check("rst_s_data", 32'(bus.s_data), 'h00);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_m_ready", 32'(bus.m_ready), 1);

    // Streaming 0x01..0x0A with s_ready held high
    bus.s_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      drv(c < 10, 8'(c + 1));
      if (c < 10) check("stream_m_ready", 32'(bus.m_ready), 1);
      check("stream_s_valid", 32'(bus.s_valid), (c >= 3 && c < 13) ? 1 : 0);
      if (c >= 3 && c < 13) check("stream_s_data", 32'(bus.s_data), c - 2);
      cyc();
    end

    // Backpressure fill
    bus.s_ready = 1'b0;
    drv(1'b1, 8'h11); check("bp_m_ready_11", 32'(bus.m_ready), 1); cyc();
    drv(1'b1, 8'h22); check("bp_m_ready_22", 32'(bus.m_ready), 1); cyc();
    drv(1'b1, 8'h33); check("bp_m_ready_33", 32'(bus.m_ready), 1); cyc();
    drv(1'b1, 8'h44);
    check("bp_full_m_ready", 32'(bus.m_ready), 0);
    check("bp_full_occ", 32'(occupancy), 3);
    check("bp_full_s_valid", 32'(bus.s_valid), 1);
    check("bp_full_s_data", 32'(bus.s_data), 'h11);
    cyc();
    drv(1'b1, 8'h44);
    check("bp_hold_m_ready", 32'(bus.m_ready), 0);
    check("bp_hold_s_data", 32'(bus.s_data), 'h11);
    bus.s_ready = 1'b1;
    #1;
    check("bp_drain_m_ready", 32'(bus.m_ready), 1);
    cyc();
    drv(1'b0, 8'h00);
    check("bp_out_22", 32'(bus.s_data), 'h22);
    check("bp_occ_after_swap", 32'(occupancy), 3);
    cyc();
    check("bp_out_33", 32'(bus.s_data), 'h33);
    check("bp_occ_2", 32'(occupancy), 2);
    cyc();
    check("bp_out_44", 32'(bus.s_data), 'h44);
    check("bp_occ_1", 32'(occupancy), 1);
    cyc();
    check("bp_empty_s_valid", 32'(bus.s_valid), 0);
    check("bp_empty_occ", 32'(occupancy), 0);

    // Bubble collapse
    bus.s_ready = 1'b0;
    drv(1'b1, 8'hA0); cyc();
    drv(1'b0, 8'h00); cyc();
    cyc();
    drv(1'b1, 8'hB0);
    check("bub_m_ready", 32'(bus.m_ready), 1);
    cyc();
    drv(1'b0, 8'h00);
    check("bub_occ", 32'(occupancy), 2);
    check("bub_s_data", 32'(bus.s_data), 'hA0);
    cyc();
    bus.s_ready = 1'b1;
    #1;
    check("bub_out_a0_valid", 32'(bus.s_valid), 1);
    check("bub_out_a0", 32'(bus.s_data), 'hA0);
    cyc();
    check("bub_out_b0_valid", 32'(bus.s_valid), 1);
    check("bub_out_b0", 32'(bus.s_data), 'hB0);
    cyc();
    check("bub_empty", 32'(bus.s_valid), 0);

    // Flush with a beat offered
    bus.s_ready = 1'b0;
    drv(1'b1, 8'h55); cyc();
    drv(1'b1, 8'h66); cyc();
    drv(1'b1, 8'h77); cyc();
    flush = 1'b1;
    drv(1'b1, 8'h88);
    check("fl_occ_before", 32'(occupancy), 3);
    check("fl_m_ready", 32'(bus.m_ready), 0);
    check("fl_s_valid_unmasked", 32'(bus.s_valid), 1);
    check("fl_s_data", 32'(bus.s_data), 'h55);
    cyc();
    flush = 1'b0;
    drv(1'b0, 8'h00);
    check("fl_occ_after", 32'(occupancy), 0);
    check("fl_s_valid_after", 32'(bus.s_valid), 0);
    drv(1'b1, 8'h88);
    check("fl_reaccept_m_ready", 32'(bus.m_ready), 1);
    cyc();
    drv(1'b0, 8'h00);
    bus.s_ready = 1'b1;
    check("fl_88_occ", 32'(occupancy), 1);
    check("fl_88_lat1", 32'(bus.s_valid), 0);
    cyc();
    check("fl_88_lat2", 32'(bus.s_valid), 0);
    cyc();
    check("fl_88_valid", 32'(bus.s_valid), 1);
    check("fl_88_data", 32'(bus.s_data), 'h88);
    cyc();
    check("fl_88_drained", 32'(bus.s_valid), 0);

    // Reset mid-stream
    bus.s_ready = 1'b0;
    drv(1'b1, 8'h91); cyc();
    drv(1'b1, 8'h92); cyc();
    drv(1'b0, 8'h00);
    check("mr_occ_before", 32'(occupancy), 2);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    check("mr_s_valid", 32'(bus.s_valid), 0);
    check("mr_occ", 32'(occupancy), 0);
    check("mr_s_data", 32'(bus.s_data), 'h00);
    bus.s_ready = 1'b1;
    drv(1'b1, 8'hC3);
    check("mr_c3_m_ready", 32'(bus.m_ready), 1);
    cyc();
    drv(1'b0, 8'h00);
    check("mr_lat1", 32'(bus.s_valid), 0);
    cyc();
    check("mr_lat2", 32'(bus.s_valid), 0);
    cyc();
    check("mr_c3_valid", 32'(bus.s_valid), 1);
    check("mr_c3_data", 32'(bus.s_data), 'hC3);
    cyc();
    check("mr_c3_alone", 32'(bus.s_valid), 0);
    check("mr_final_occ", 32'(occupancy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/forward_registered_pipe.md
Name: forward_registered_pipe

Overview:
- DEPTH-stage valid/ready pipeline; every stage registers valid and data, so s_valid/s_data come straight from flops with no combinational path from m_valid/m_data.
- Counterpart to the team's backward-registered slice, which registers the ready path. This block registers the forward path.
- Sits between a master and a slave on long forward timing paths.
- Bubbles collapse, sustained throughput is one beat per cycle, and a synchronous flush discards in-flight beats.

Parameters:
WIDTH, 8, data bus width in bits
DEPTH, 3, number of register stages (>=1)
CNT_W, $clog2(DEPTH+1), width of occupancy output (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
flush  input  1  synchronous discard of all in-flight beats
m_valid  input  1  upstream beat valid
m_ready  output  1  upstream accept
m_data  input  WIDTH  upstream payload
s_valid  output  1  downstream beat valid (registered)
s_ready  input  1  downstream accept
s_data  output  WIDTH  downstream payload (registered)
occupancy  output  CNT_W  number of valid stages (registered state, popcount)

Behaviour:
- State: vld[i] and dat[i] for i = 0..DEPTH-1. Stage 0 faces the master; stage DEPTH-1 drives s_valid/s_data.
- Reset (rst_n=0 at posedge): all vld=0, all dat=0.
  - Therefore s_valid=0, s_data=0, occupancy=0 in the cycle after reset.
  - m_ready is 1 after reset, because it is combinational from the empty state.
- Ready chain (combinational):
  - rdy[DEPTH-1] = s_ready | ~vld[DEPTH-1]
  - rdy[i] = rdy[i+1] | ~vld[i]
  - m_ready = rdy[0] & ~flush
- Stage update on each posedge when flush=0:
  - Stage i with rdy[i]=1 loads vld[i]/dat[i] from its predecessor. Stage 0 takes m_valid/m_data; stage i>0 takes vld[i-1]/dat[i-1].
  - Stage with rdy[i]=0 holds.
  - dat[i] is updated only when the incoming valid is 1.
  - The bubble-collapse rule: an empty stage is always ready, even if downstream is stalled.
- Handshakes: upstream transfer when m_valid & m_ready; downstream transfer when s_valid & s_ready.
- Latency: a beat accepted at edge N appears on s_valid at edge N+DEPTH-1 (visible the cycle after). This assumes no stalls. Minimum in-to-out latency is DEPTH cycles.
- Throughput: with s_ready held 1, one beat per cycle indefinitely, with no bubbles inserted.
- Ordering: strict FIFO, no beat dropped or duplicated except by flush.
- Protocol rules:
  - s_valid, once 1, stays 1 and s_data stays stable until s_ready=1.
  - The block tolerates an upstream that drops m_valid without a handshake, since only handshaken beats enter.
- Full: all vld=1 and s_ready=0 gives m_ready=0 and occupancy=DEPTH.
- Full with s_ready=1: m_ready=1 in the same cycle, so accept and drain happen simultaneously and occupancy is unchanged.
- Empty: occupancy=0, s_valid=0, m_ready=1 regardless of s_ready.
- flush=1:
  - m_ready forced 0 that cycle; no upstream handshake occurs.
  - s_valid is not masked. A downstream handshake in the flush cycle still counts as delivered.
  - At the edge, all vld clear and dat holds. Next cycle occupancy=0, s_valid=0.
  - flush takes priority over all loads.
- Reset asserted mid-stream: all in-flight beats discarded, same end state as flush. rst_n dominates flush.
- occupancy = popcount(vld), saturates naturally at DEPTH, never exceeds it.
- DEPTH=1 degenerates to a single forward-registered slice with m_ready = s_ready | ~s_valid.

Test Plan:
- Reset then idle (DEPTH=3): rst_n=0 for 2 cycles -> s_valid=0, s_data=0x00, occupancy=0, m_ready=1.
- Streaming: s_ready=1; send 0x01..0x0A back-to-back -> s_valid first high 3 cycles after first accept; 0x01..0x0A out on consecutive cycles; m_ready never 0.
- Backpressure fill: s_ready=0; offer 0x11,0x22,0x33,0x44 -> first 3 accepted, m_ready=0 while 0x44 offered; occupancy=3; s_data=0x11 stable. Raise s_ready -> 0x11,0x22,0x33,0x44 delivered in order; 0x44 accepted the same cycle 0x11 leaves.
- Bubble collapse: send 0xA0, idle 2 cycles, send 0xB0 with s_ready=0 -> both held, occupancy=2, adjacent stages. Release s_ready -> 0xA0 then 0xB0 on consecutive cycles.
- Flush: occupancy=3 holding 0x55,0x66,0x77, s_ready=0; pulse flush with m_valid=1, m_data=0x88 -> m_ready=0 that cycle. Next cycle occupancy=0, s_valid=0; 0x88 not captured and must be accepted after flush.
- Reset mid-stream: occupancy=2, assert rst_n=0 for 1 cycle -> s_valid=0, occupancy=0. Old beats never appear; a new beat 0xC3 emerges alone after 3 cycles.
